serial_to_unfold3: RTL and testbench
====================================

// Module: serial_to_unfold3
// PURPOSE
//  Serial-to-parallel front end for the 3-way unfolded FIR (myfir).
//  Takes one sample per valid cycle and packs each group of three consecutive
//  samples x[3k], x[3k+1], x[3k+2] into one parallel word with a single valid strobe.
//  The unfolded filter consumes one sample group per VOUT pulse.
//  FLUSH closes a partial group at end of stream by zero-padding the missing lanes.
// PARAMETERS
//  NBIT   12   sample width in bits (two's complement; passed through, never modified)
// PORTS
//  clk        in   1     single clock, all logic on rising edge
//  RST        in   1     synchronous reset, active-high
//  DIN        in   NBIT  serial sample, valid when VIN=1
//  VIN        in   1     input valid; one sample accepted per cycle with VIN=1
//  FLUSH      in   1     end-of-stream request: emit any partial group zero-padded
//  DOUT3k     out  NBIT  lane 0: oldest sample of group, x[3k]
//  DOUT3k1    out  NBIT  lane 1: x[3k+1]
//  DOUT3k2    out  NBIT  lane 2: newest sample of group, x[3k+2]
//  VOUT       out  1     one-cycle strobe: DOUT* hold a new group this cycle
//  PADDED     out  1     qualifies VOUT: 1 = group was closed by FLUSH (lanes zeroed)
// BEHAVIOUR
//  Reset (RST=1 at edge): phase<=0, hold regs<=0, DOUT*<=0, VOUT<=0, PADDED<=0.
//   Reset mid-group discards the partial group; no VOUT is produced for it.
//  State: phase counter 0->1->2->0, advancing only on VIN=1. No other FSM states.
//   Two hold regs h0, h1 capture samples at phase 0 and 1.
//  Normal emit: VIN=1 with phase==2 at edge n:
//   DOUT3k<=h0, DOUT3k1<=h1, DOUT3k2<=DIN; VOUT=1, PADDED=0 during cycle n+1.
//   phase<=0. Latency is 1 clk from the third sample to VOUT.
//  VIN=0 cycles: phase and hold regs unchanged; gaps of any length are allowed.
//  DOUT* hold their last value between strobes. VOUT is 0 on every cycle except strobes.
//  Back-to-back: a continuous VIN=1 stream gives VOUT on every 3rd cycle.
//   A new group may start on the cycle its predecessor is emitted.
//  FLUSH (sampled at the same edge as VIN):
//   phase==0, VIN=0             : no-op; no VOUT.
//   phase==0, VIN=1             : emit {DIN,0,0}, PADDED=1; phase<=0.
//   phase==1, VIN=0             : emit {h0,0,0}, PADDED=1; phase<=0.
//   phase==1, VIN=1             : emit {h0,DIN,0}, PADDED=1; phase<=0.
//   phase==2, VIN=0             : emit {h0,h1,0}, PADDED=1; phase<=0.
//   phase==2, VIN=1             : normal emit, PADDED=0 (group complete, FLUSH ignored).
//   In every case the emit uses the same 1-clk latency as a normal emit.
//  After any emit, h0/h1 need not be cleared; unused lanes are forced to 0 on output.
//  No back-pressure: the downstream stage always accepts. RST has priority over VIN and FLUSH.
// TESTING
//  1) RST=1 for 2 clk -> DOUT*=0, VOUT=0, PADDED=0; RST released -> outputs stay 0.
//  2) VIN=1 for 6 consecutive clk, DIN=1,2,3,4,5,6:
//     -> VOUT in cycles 4 and 7 (counting the first VIN cycle as 1).
//     -> first group {1,2,3}, second group {4,5,6}; PADDED=0 on both.
//  3) DIN=0x7FF, 0x800, 0xFFF sent with 2 idle cycles between each:
//     -> single VOUT 1 clk after the third sample.
//     -> lanes 0x7FF/0x800/0xFFF exact; DOUT* held afterwards.
//  4) Samples 10,11 then FLUSH=1 (VIN=0) -> VOUT=1, PADDED=1, {10,11,0}.
//     Next samples 20,21,22 -> {20,21,22}, PADDED=0.
//  5) FLUSH=1 with VIN=1 DIN=9 at phase 2 after 7,8 -> {7,8,9}, PADDED=0.
//     FLUSH=1 at phase 0 with VIN=0 -> no VOUT.
//  6) Samples 1,2 then RST=1 for 1 clk, then samples 5,6,7 -> no VOUT for 1,2.
//     -> single group {5,6,7}; no mixing of pre-reset data.

Source files
------------

// File: rtl/serial_to_unfold3.sv
// serial_to_unfold3
// Packs a serial sample stream into groups of three lanes for a 3-way
// unfolded FIR. A FLUSH closes a partial group, zero-padding missing lanes.
module serial_to_unfold3 #(
   parameter int NBIT = 12
) (
   input  logic            clk,
   input  logic            RST,
   input  logic [NBIT-1:0] DIN,
   input  logic            VIN,
   input  logic            FLUSH,
   output logic [NBIT-1:0] DOUT3k,
   output logic [NBIT-1:0] DOUT3k1,
   output logic [NBIT-1:0] DOUT3k2,
   output logic            VOUT,
   output logic            PADDED
);

   // phase counts samples already held in the current group (0..2)
   logic [1:0]      phase_reg, phase_next;
   logic [NBIT-1:0] h0_reg, h0_next;
   logic [NBIT-1:0] h1_reg, h1_next;

   // Lane values and strobe for the group being closed this cycle
   logic            emit_next;
   logic            padded_next;
   logic [NBIT-1:0] lane0_next, lane1_next, lane2_next;

   // State register: phase counter and the two hold registers
   always_ff @(posedge clk) begin
      if (RST) begin
         phase_reg <= 2'd0;
         h0_reg    <= '0;
         h1_reg    <= '0;
      end else begin
         phase_reg <= phase_next;
         h0_reg    <= h0_next;
         h1_reg    <= h1_next;
      end
   end

   // Next-state logic: advance on VIN, return to phase 0 whenever a group closes
   always_comb begin
      phase_next = phase_reg;
      h0_next    = h0_reg;
      h1_next    = h1_reg;
      case (phase_reg)
         2'd0: begin
            if (VIN && !FLUSH) begin
               h0_next    = DIN;
               phase_next = 2'd1;
            end
         end
         2'd1: begin
            if (FLUSH) begin
               phase_next = 2'd0;
            end else if (VIN) begin
               h1_next    = DIN;
               phase_next = 2'd2;
            end
         end
         2'd2: begin
            if (VIN || FLUSH) begin
               phase_next = 2'd0;
            end
         end
         default: phase_next = 2'd0;
      endcase
   end

   // Output decode: which lanes carry data for a closing group; unused lanes are zero
   always_comb begin
      emit_next   = 1'b0;
      padded_next = 1'b0;
      lane0_next  = '0;
      lane1_next  = '0;
      lane2_next  = '0;
      case (phase_reg)
         2'd0: begin
            if (VIN && FLUSH) begin
               emit_next   = 1'b1;
               padded_next = 1'b1;
               lane0_next  = DIN;
            end
         end
         2'd1: begin
            if (FLUSH) begin
               emit_next   = 1'b1;
               padded_next = 1'b1;
               lane0_next  = h0_reg;
               lane1_next  = VIN ? DIN : '0;
            end
         end
         2'd2: begin
            if (VIN) begin
               // A complete group wins over a coincident FLUSH
               emit_next   = 1'b1;
               lane0_next  = h0_reg;
               lane1_next  = h1_reg;
               lane2_next  = DIN;
            end else if (FLUSH) begin
               emit_next   = 1'b1;
               padded_next = 1'b1;
               lane0_next  = h0_reg;
               lane1_next  = h1_reg;
            end
         end
         default: emit_next = 1'b0;
      endcase
   end

   // Output registers: lanes update only on a strobe and hold otherwise
   always_ff @(posedge clk) begin
      if (RST) begin
         DOUT3k  <= '0;
         DOUT3k1 <= '0;
         DOUT3k2 <= '0;
         VOUT    <= 1'b0;
         PADDED  <= 1'b0;
      end else begin
         VOUT   <= emit_next;
         PADDED <= padded_next;
         if (emit_next) begin
            DOUT3k  <= lane0_next;
            DOUT3k1 <= lane1_next;
            DOUT3k2 <= lane2_next;
         end
      end
   end

endmodule

// File: tb/tb_serial_to_unfold3.sv
// tb_serial_to_unfold3
// Scoreboard bench: each expected group is queued with the cycle it must
// appear in; a negedge monitor checks VOUT every cycle and lanes on strobes.
module tb_serial_to_unfold3;
   localparam int NBIT = 12;

   logic            clk = 1'b0;
   logic            rst;
   logic            vin;
   logic            flush;
   logic [NBIT-1:0] din;
   logic [NBIT-1:0] dout0, dout1, dout2;
   logic            vout, padded;

   serial_to_unfold3 #(.NBIT(NBIT)) dut (
      .clk     (clk),
      .RST     (rst),
      .DIN     (din),
      .VIN     (vin),
      .FLUSH   (flush),
      .DOUT3k  (dout0),
      .DOUT3k1 (dout1),
      .DOUT3k2 (dout2),
      .VOUT    (vout),
      .PADDED  (padded)
   );

   always #5 clk = ~clk;

   typedef struct {
      int unsigned     cyc;
      logic [NBIT-1:0] d0;
      logic [NBIT-1:0] d1;
      logic [NBIT-1:0] d2;
      logic            pad;
   } grp_t;

   grp_t        exp_q[$];
   int unsigned cyc = 0;
   int          checks = 0;
   int          failures = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // Monitor: VOUT must be high exactly in the cycles the scoreboard predicts
   always @(negedge clk) begin
      logic due;
      grp_t g;
      due = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
      check_eq("vout", {31'd0, vout}, {31'd0, due});
      if (due) begin
         g = exp_q.pop_front();
         if (vout) begin
            check_eq("lane0", {20'd0, dout0}, {20'd0, g.d0});
            check_eq("lane1", {20'd0, dout1}, {20'd0, g.d1});
            check_eq("lane2", {20'd0, dout2}, {20'd0, g.d2});
            check_eq("padded", {31'd0, padded}, {31'd0, g.pad});
            $display("group cycle=%0d lanes=%03h %03h %03h padded=%0b", cyc, dout0, dout1, dout2, padded);
         end
      end
   end

   // Queue a group expected one clock after the next driven edge
   task automatic expect_grp(input logic [NBIT-1:0] d0, input logic [NBIT-1:0] d1,
                             input logic [NBIT-1:0] d2, input logic pad);
      grp_t g;
      g.cyc = cyc + 1;
      g.d0  = d0;
      g.d1  = d1;
      g.d2  = d2;
      g.pad = pad;
      exp_q.push_back(g);
   endtask

   // Drive one clock of stimulus
   task automatic step(input logic v, input logic [NBIT-1:0] d, input logic f);
      vin   = v;
      din   = d;
      flush = f;
      @(posedge clk);
      #1;
      vin   = 1'b0;
      flush = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0);
   endtask

   initial begin
      rst = 1'b1; vin = 1'b0; flush = 1'b0; din = '0;
      // Reset held for two clocks
      repeat (2) @(posedge clk);
      #1;
      check_eq("rst_dout0", {20'd0, dout0}, 32'd0);
      check_eq("rst_dout1", {20'd0, dout1}, 32'd0);
      check_eq("rst_dout2", {20'd0, dout2}, 32'd0);
      check_eq("rst_padded", {31'd0, padded}, 32'd0);
      rst = 1'b0;
      idle(2);
      check_eq("post_rst_dout0", {20'd0, dout0}, 32'd0);

      // Continuous stream of six samples
      for (int i = 1; i <= 6; i++) begin
         if (i == 3) expect_grp(12'd1, 12'd2, 12'd3, 1'b0);
         if (i == 6) expect_grp(12'd4, 12'd5, 12'd6, 1'b0);
         step(1'b1, 12'(i), 1'b0);
      end
      idle(2);

      // Extreme values with idle gaps, then hold check
      step(1'b1, 12'h7FF, 1'b0);
      idle(2);
      step(1'b1, 12'h800, 1'b0);
      idle(2);
      expect_grp(12'h7FF, 12'h800, 12'hFFF, 1'b0);
      step(1'b1, 12'hFFF, 1'b0);
      idle(3);
      check_eq("hold_dout0", {20'd0, dout0}, 32'h7FF);
      check_eq("hold_dout1", {20'd0, dout1}, 32'h800);
      check_eq("hold_dout2", {20'd0, dout2}, 32'hFFF);

      // Flush at phase 2 without VIN, then a normal group
      step(1'b1, 12'd10, 1'b0);
      step(1'b1, 12'd11, 1'b0);
      expect_grp(12'd10, 12'd11, 12'd0, 1'b1);
      step(1'b0, 12'd0, 1'b1);
      idle(1);
      step(1'b1, 12'd20, 1'b0);
      step(1'b1, 12'd21, 1'b0);
      expect_grp(12'd20, 12'd21, 12'd22, 1'b0);
      step(1'b1, 12'd22, 1'b0);
      idle(1);

      // Flush coinciding with the completing sample is ignored; flush at phase 0 idle is a no-op
      step(1'b1, 12'd7, 1'b0);
      step(1'b1, 12'd8, 1'b0);
      expect_grp(12'd7, 12'd8, 12'd9, 1'b0);
      step(1'b1, 12'd9, 1'b1);
      idle(1);
      step(1'b0, 12'd0, 1'b1);
      idle(2);

      // Flush with VIN at phase 0 and phase 1, then phase 1 without VIN
      expect_grp(12'd33, 12'd0, 12'd0, 1'b1);
      step(1'b1, 12'd33, 1'b1);
      step(1'b1, 12'd40, 1'b0);
      expect_grp(12'd40, 12'd41, 12'd0, 1'b1);
      step(1'b1, 12'd41, 1'b1);
      step(1'b1, 12'd45, 1'b0);
      expect_grp(12'd45, 12'd0, 12'd0, 1'b1);
      step(1'b0, 12'd0, 1'b1);
      // Group started on the cycle its predecessor is emitted
      step(1'b1, 12'd50, 1'b0);
      step(1'b1, 12'd51, 1'b0);
      expect_grp(12'd50, 12'd51, 12'd52, 1'b0);
      step(1'b1, 12'd52, 1'b0);
      idle(1);

      // Reset in mid-group discards the partial group
      step(1'b1, 12'd1, 1'b0);
      step(1'b1, 12'd2, 1'b0);
      rst = 1'b1;
      idle(1);
      rst = 1'b0;
      check_eq("midrst_dout2", {20'd0, dout2}, 32'd0);
      step(1'b1, 12'd5, 1'b0);
      step(1'b1, 12'd6, 1'b0);
      expect_grp(12'd5, 12'd6, 12'd7, 1'b0);
      step(1'b1, 12'd7, 1'b0);
      idle(3);

      check_eq("queue_empty", exp_q.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
